// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator: opcodes, frame sizes and the
// master state encoding.
package spi_pkg;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    localparam int FRAME_BITS = 10;
    localparam int RX_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_CMD,
        ST_SHIFT,
        ST_WAIT,
        ST_RECV,
        ST_GAP
    } master_state_t;

endpackage

// File: rtl/spi_master_if.sv
// Host-side command/response port of the SPI initiator. The host is the
// master of this port; spi_master attaches through the slave modport.
interface spi_master_if;
    import spi_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [FRAME_BITS-1:0] cmd_data;
    logic                  rsp_valid;
    logic [RX_BITS-1:0]    rsp_data;
    logic                  cmd_err;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data,
        input  cmd_err
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready,
        output rsp_valid,
        output rsp_data,
        output cmd_err
    );

endinterface

// File: rtl/spi_master_shifter.sv
// Datapath of the SPI initiator: a load/shift-left register whose MSB is the
// registered MOSI bit, and a MISO capture register that publishes a whole
// byte only when the last bit arrives.
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] load_word,
    input  logic                  shift_en,
    input  logic                  cap_en,
    input  logic                  cap_last,
    input  logic                  miso,
    output logic                  mosi,
    output logic [RX_BITS-1:0]    rx_data
);

    logic [FRAME_BITS-1:0] tx_sr;
    logic [RX_BITS-2:0]    rx_sr;

    // Transmit register: zeros shift in behind the word, so after the tenth
    // shift the MSB (and therefore MOSI) returns to 0 without extra logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr <= '0;
        end else if (load) begin
            tx_sr <= load_word;
        end else if (shift_en) begin
            tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign mosi = tx_sr[FRAME_BITS-1];

    // Receive path: first seven bits collect in rx_sr, the eighth completes
    // the byte so rx_data only changes once per read-data frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr   <= '0;
            rx_data <= '0;
        end else if (cap_en) begin
            rx_sr <= {rx_sr[RX_BITS-3:0], miso};
            if (cap_last) begin
                rx_data <= {rx_sr, miso};
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI initiator: accepts 10-bit command words from the host, frames them on
// SS_n/MOSI, and for read-data frames waits RD_LATENCY cycles then captures
// eight MISO bits. IDLE_GAP must be at least 1.
module spi_master
    import spi_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int IDLE_GAP   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.slave  host,
    output logic         busy,
    output logic         SS_n,
    output logic         MOSI,
    input  logic         MISO
);

    localparam logic [3:0] TX_LAST   = 4'(FRAME_BITS - 1);
    localparam logic [3:0] RX_LAST   = 4'(RX_BITS - 1);
    localparam logic [7:0] WAIT_LAST = 8'(RD_LATENCY - 1);
    localparam logic [7:0] GAP_LAST  = 8'(IDLE_GAP - 1);

    master_state_t state_q, state_d;
    logic [3:0]    bit_cnt;
    logic [7:0]    wait_cnt;
    logic [1:0]    op_q;
    logic          rd_pend;
    logic          rsp_valid_q, cmd_err_q;

    logic          accept, reject;
    logic          load, shift_en, cap_en, cap_last;
    logic          rd_set, rd_clr, err_d, rsp_v_d, ss_low_d;
    logic [RX_BITS-1:0] rx_data;

    assign host.cmd_ready = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign host.rsp_valid = rsp_valid_q;
    assign host.cmd_err   = cmd_err_q;
    assign host.rsp_data  = rx_data;

    assign accept = host.cmd_valid && host.cmd_ready;
    assign reject = accept && (host.cmd_data[FRAME_BITS-1 -: 2] == RD_DATA) && !rd_pend;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        cap_en   = 1'b0;
        cap_last = 1'b0;
        rd_set   = 1'b0;
        rd_clr   = 1'b0;
        err_d    = 1'b0;
        rsp_v_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (reject) begin
                    state_d = ST_GAP;
                    err_d   = 1'b1;
                end else if (accept) begin
                    state_d = ST_START;
                    load    = 1'b1;
                end
            end
            ST_START: state_d = ST_CMD;
            ST_CMD:   state_d = ST_SHIFT;
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt == TX_LAST) begin
                    if (op_q == RD_DATA) begin
                        state_d = (RD_LATENCY == 0) ? ST_RECV : ST_WAIT;
                    end else begin
                        state_d = ST_GAP;
                        rd_set  = (op_q == RD_ADDR);
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                cap_en = 1'b1;
                if (bit_cnt == RX_LAST) begin
                    cap_last = 1'b1;
                    rsp_v_d  = 1'b1;
                    rd_clr   = 1'b1;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (wait_cnt == GAP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bit and wait counters restart on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            wait_cnt <= '0;
        end else if (state_d != state_q) begin
            bit_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            if (state_q == ST_SHIFT || state_q == ST_RECV) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (state_q == ST_WAIT || state_q == ST_GAP) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // Opcode of the frame in flight, latched with the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= WR_ADDR;
        end else if (load) begin
            op_q <= host.cmd_data[FRAME_BITS-1 -: 2];
        end
    end

    // Tracks whether a read-addr has been sent without a matching read-data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
        end else if (rd_set) begin
            rd_pend <= 1'b1;
        end else if (rd_clr) begin
            rd_pend <= 1'b0;
        end
    end

    assign ss_low_d = (state_d == ST_START) || (state_d == ST_CMD) || (state_d == ST_SHIFT) ||
                      (state_d == ST_WAIT)  || (state_d == ST_RECV);

    // Registered SS_n and host pulses, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n        <= 1'b1;
            rsp_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            SS_n        <= !ss_low_d;
            rsp_valid_q <= rsp_v_d;
            cmd_err_q   <= err_d;
        end
    end

    spi_master_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_word (host.cmd_data),
        .shift_en  (shift_en),
        .cap_en    (cap_en),
        .cap_last  (cap_last),
        .miso      (MISO),
        .mosi      (MOSI),
        .rx_data   (rx_data)
    );

endmodule

// File: tb/tb_spi_master.sv
// Directed testbench for spi_master with a behavioural SPI slave + RAM model
// that samples MOSI and drives MISO on the falling edge.
module tb_spi_master;

    localparam int RDL = 2;
    localparam int GAP = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic busy, ss_n, mosi;
    logic miso = 1'b1;

    int checks = 0;
    int passes = 0;

    spi_master_if bus ();

    spi_master #(.RD_LATENCY(RDL), .IDLE_GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (bus),
        .busy  (busy),
        .SS_n  (ss_n),
        .MOSI  (mosi),
        .MISO  (miso)
    );

    always #5 clk = ~clk;

    // Slave + RAM model: counts cycles of SS_n low, shifts in word bits at
    // counts 3..12 and returns the read byte at counts 13+RDL..20+RDL.
    int         s_cnt = 0;
    logic [9:0] s_word = '0;
    logic [9:0] s_last_word = '0;
    logic [7:0] s_addr = '0;
    logic [7:0] s_rd_addr = '0;
    logic [7:0] s_rd_byte = '0;
    logic [7:0] s_mem [256];
    logic       s_force_en = 1'b0;
    logic [7:0] s_force_byte = '0;

    always @(negedge clk) begin
        if (ss_n) begin
            s_cnt = 0;
            miso  = 1'b1;
        end else begin
            s_cnt++;
            if (s_cnt >= 3 && s_cnt <= 12) s_word = {s_word[8:0], mosi};
            if (s_cnt == 12) begin
                s_last_word = s_word;
                case (s_word[9:8])
                    2'b00: s_addr = s_word[7:0];
                    2'b01: s_mem[s_addr] = s_word[7:0];
                    2'b10: s_rd_addr = s_word[7:0];
                    default: s_rd_byte = s_force_en ? s_force_byte : s_mem[s_rd_addr];
                endcase
            end
            if (s_cnt >= 13 + RDL && s_cnt <= 20 + RDL) begin
                int idx;
                idx  = 20 + RDL - s_cnt;
                miso = s_rd_byte[idx];
            end else begin
                miso = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [9:0] w);
        int n = 0;
        while (!bus.cmd_ready && n < 60) begin
            tick();
            n++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            $display("[TB] FAIL send_cmd_timeout: cmd_ready=%b want 1", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = w;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            $display("[TB] FAIL wait_idle_timeout: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset();
        logic [13:0] got;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        got = {ss_n, mosi, bus.rsp_valid, bus.cmd_err, busy, bus.cmd_ready, bus.rsp_data};
        checks++;
        if (got !== {6'b100001, 8'h00})
            $display("[TB] FAIL reset_state: got %b want %b", got, {6'b100001, 8'h00});
        else passes++;
    endtask

    task automatic test_write_addr();
        logic [9:0] w;
        logic [3:0] got, exp;
        logic       expm;
        w = 10'h0A5;
        send_cmd(w);
        bus.cmd_data = 10'h3FF;
        for (int k = 0; k < 14; k++) begin
            if (k < 2)       expm = w[9];
            else if (k < 12) expm = w[11 - k];
            else             expm = 1'b0;
            exp = {(k >= 12), expm, (k < 13), (k == 13)};
            got = {ss_n, mosi, busy, bus.cmd_ready};
            checks++;
            if (got !== exp)
                $display("[TB] FAIL write_cycle%0d {ss_n,mosi,busy,ready}: got %b want %b", k, got, exp);
            else passes++;
            tick();
        end
        checks++;
        if (s_last_word !== w)
            $display("[TB] FAIL write_slave_word: got %h want %h", s_last_word, w);
        else passes++;
    endtask

    task automatic test_rd_reject(input string tag, input logic [7:0] held);
        logic [3:0] got, exp;
        send_cmd(10'h300);
        for (int k = 0; k < 4; k++) begin
            exp = (k == 0) ? 4'b1101 : 4'b0100;
            got = {bus.cmd_err, ss_n, bus.rsp_valid, busy};
            checks++;
            if (got !== exp)
                $display("[TB] FAIL reject_%s_cycle%0d {err,ss_n,rsp_v,busy}: got %b want %b", tag, k, got, exp);
            else passes++;
            tick();
        end
        checks++;
        if (bus.rsp_data !== held)
            $display("[TB] FAIL reject_%s_rsp_data: got %h want %h", tag, bus.rsp_data, held);
        else passes++;
    endtask

    task automatic test_read();
        int ss_low = 0, pulses = 0, at_k = -1, errs = 0;
        s_force_en   = 1'b1;
        s_force_byte = 8'hC3;
        send_cmd(10'h212);
        wait_idle();
        send_cmd(10'h300);
        for (int k = 0; k < 30; k++) begin
            if (!ss_n) ss_low++;
            if (bus.rsp_valid) begin
                pulses++;
                at_k = k;
            end
            if (bus.cmd_err) errs++;
            tick();
        end
        s_force_en = 1'b0;
        checks++;
        if (ss_low !== 20 + RDL) $display("[TB] FAIL read_ss_low_cycles: got %0d want %0d", ss_low, 20 + RDL);
        else passes++;
        checks++;
        if (pulses !== 1) $display("[TB] FAIL read_rsp_valid_pulses: got %0d want 1", pulses);
        else passes++;
        checks++;
        if (at_k !== 20 + RDL) $display("[TB] FAIL read_rsp_valid_cycle: got %0d want %0d", at_k, 20 + RDL);
        else passes++;
        checks++;
        if (errs !== 0) $display("[TB] FAIL read_cmd_err: got %0d want 0", errs);
        else passes++;
        checks++;
        if (bus.rsp_data !== 8'hC3) $display("[TB] FAIL read_rsp_data: got %h want c3", bus.rsp_data);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int   acc = 0, rise = -1, fall = -1;
        logic prev_ss;
        wait_idle();
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 10'h011;
        prev_ss = ss_n;
        for (int k = 0; k < 40; k++) begin
            if (bus.cmd_valid && bus.cmd_ready) acc++;
            tick();
            if (acc == 1) bus.cmd_data = 10'h155;
            if (acc == 2) bus.cmd_valid = 1'b0;
            if (!prev_ss && ss_n && rise < 0) rise = k;
            if (prev_ss && !ss_n && rise >= 0 && fall < 0) fall = k;
            prev_ss = ss_n;
        end
        bus.cmd_valid = 1'b0;
        wait_idle();
        checks++;
        if (acc !== 2) $display("[TB] FAIL b2b_accepts: got %0d want 2", acc);
        else passes++;
        checks++;
        if (fall - rise !== GAP + 1) $display("[TB] FAIL b2b_gap: got %0d want %0d", fall - rise, GAP + 1);
        else passes++;
        checks++;
        if (s_mem[8'h11] !== 8'h55) $display("[TB] FAIL b2b_slave_mem: got %h want 55", s_mem[8'h11]);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [1:0] pre;
        logic [4:0] post;
        int         bad = 0;
        send_cmd(10'h2AB);
        wait_idle();
        send_cmd(10'h3FF);
        for (int k = 0; k < 6; k++) tick();
        pre = {ss_n, mosi};
        checks++;
        if (pre !== 2'b01) $display("[TB] FAIL midrst_pre {ss_n,mosi}: got %b want 01", pre);
        else passes++;
        rst_n = 1'b0;
        #1;
        post = {ss_n, mosi, busy, bus.rsp_valid, bus.cmd_err};
        checks++;
        if (post !== 5'b10000) $display("[TB] FAIL midrst_async {ss_n,mosi,busy,rsp_v,err}: got %b want 10000", post);
        else passes++;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (bus.rsp_valid || bus.cmd_err || !ss_n) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) $display("[TB] FAIL midrst_quiet: got %0d events want 0", bad);
        else passes++;
        test_rd_reject("after_reset", 8'h00);
    endtask

    task automatic test_loopback();
        int n = 0;
        send_cmd(10'h012);
        send_cmd(10'h15A);
        send_cmd(10'h212);
        send_cmd(10'h300);
        while (!bus.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1) $display("[TB] FAIL loopback_rsp_valid: got %b want 1", bus.rsp_valid);
        else passes++;
        checks++;
        if (bus.rsp_data !== 8'h5A) $display("[TB] FAIL loopback_rsp_data: got %h want 5a", bus.rsp_data);
        else passes++;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_rd_reject("no_pend", 8'h00);
        test_read();
        test_rd_reject("after_read", 8'hC3);
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/spi_master.md
# spi_master

Serial initiator for the system SPI link: accepts 10-bit command words from a host-side valid/ready port, frames them onto SS_n/MOSI for the SPI slave plus RAM subsystem, and returns the 8-bit RAM read data captured from MISO. It sits between the host or control FSM and the SPI slave, on the same single clock domain.

## Interface
- RD_LATENCY, default 2: SS_n-low wait cycles between the last MOSI bit and the first MISO sample of a read-data frame.
- IDLE_GAP, default 1: minimum cycles in the GAP state, with SS_n high, after every frame.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  high only in IDLE; a transfer occurs when cmd_valid && cmd_ready at a clock edge.
- cmd_data  in  10  [9:8] opcode: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data. [7:0] payload.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid in that cycle.
- rsp_data  out  8  captured read byte; holds its value until the next read-data completion.
- cmd_err  out  1  one-cycle pulse when a read-data command is rejected.
- busy  out  1  high in every state except IDLE.
- SS_n  out  1  slave select, active low, registered.
- MOSI  out  1  serial data out, MSB first, registered.
- MISO  in  1  serial data in from the slave.

## Operation
- Reset values: SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0, cmd_err=0, busy=0, state=IDLE, rd_pend=0, so cmd_ready=1.
- States and transitions:
  - IDLE → START on accept.
  - START (1 cycle) → CMD (1 cycle) → SHIFT (10 cycles).
  - SHIFT → WAIT if opcode is 11. Otherwise SHIFT → GAP.
  - WAIT (RD_LATENCY cycles) → RECV (8 cycles) → GAP.
  - GAP (IDLE_GAP cycles) → IDLE.
- MOSI values:
  - START and CMD drive word[9].
  - SHIFT drives word[9] down to word[0], one bit per cycle.
  - WAIT, RECV and GAP drive 0.
- SS_n is low from START through the end of SHIFT, or through the end of RECV for read-data frames. It is high in IDLE and GAP.
- The command word is latched on accept. Later changes on cmd_data have no effect on the frame in progress.
- rd_pend flag:
  - Set when a read-addr frame completes.
  - Cleared when a read-data frame completes.
  - A second read-addr while rd_pend=1 is legal; rd_pend stays 1.
- Read-data accepted with rd_pend=0: no frame is sent and SS_n stays high. cmd_err pulses in the cycle after accept, and the block returns to IDLE via GAP.
- RECV samples MISO on 8 consecutive edges into rsp_data[7] down to rsp_data[0]. rsp_valid pulses in the first GAP cycle.
- Reset mid-frame:
  - SS_n goes high asynchronously.
  - rd_pend clears.
  - No rsp_valid or cmd_err is generated.
  - A partial frame is discarded.

## Timing
- Accept at edge E0. SS_n=0 and MOSI=word[9] are valid after E0.
- The slave samples word[k] at edge E(12−k), for k=9..0.
- Write and read-addr frames: SS_n low for exactly 12 cycles and released at E12.
- Read-data frames:
  - SS_n low for 12+RD_LATENCY+8 cycles.
  - MISO bit 7 is sampled at E(12+RD_LATENCY+1).
  - rsp_valid is high in the cycle after the last sample.
- Between frames, SS_n is high for at least IDLE_GAP+1 cycles. This guarantees the slave one IDLE cycle to reset its counters.
- cmd_ready is combinational from state only. It has no path from cmd_valid.
- cmd_err and rsp_valid are never asserted in the same cycle.

## Structure
- Shared package spi_pkg holds:
  - Opcode localparams WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11.
  - FRAME_BITS=10 and RX_BITS=8.
  - The master state encoding.
- One sub-module, spi_master_shifter:
  - 10-bit load/shift-left register driving the MOSI bit.
  - 8-bit MISO capture register.
  - Controlled by load, shift_en and cap_en from the FSM.
- The FSM, bit counter, wait counter and rd_pend flag live in spi_master.

## Test plan
- Write-addr 10'h0A5 (00_1010_0101) → SS_n low 12 cycles; MOSI during SS_n low = 0,0, then 0,0,1,0,1,0,0,1,0,1; busy=1 throughout; cmd_ready low until GAP ends.
- Read-data with no prior read-addr → cmd_err one-cycle pulse at E1; SS_n never low; rsp_valid stays 0; rsp_data unchanged.
- Read-addr 10'h212, then read-data 10'h300, with a MISO model returning 8'hC3 from E(12+RD_LATENCY+1) → rsp_data=8'hC3; rsp_valid single pulse; rd_pend=0 afterwards.
- cmd_valid held high across two write commands → the second SS_n fall occurs exactly IDLE_GAP+1 cycles after the first SS_n rise.
- rst_n asserted at the 5th SHIFT cycle of a read-data frame → SS_n=1 immediately; MOSI=0; no rsp_valid; the next read-data is rejected with cmd_err.
- System loopback with the SPI slave and RAM: write-addr 8'h12, write-data 8'h5A, read-addr 8'h12, read-data → rsp_data=8'h5A.
